// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg
//   Shared definitions for the RC5-16 key schedule and the cipher datapath.
//   Contents:
//     W, C, MAX_T   : word width, key length in words, S-table depth
//     P16, Q16      : RC5 magic constants for 16-bit words
//     state_e       : key-schedule FSM state encoding
//     rotl16()      : left rotate of a 16-bit word by a 4-bit amount
// ---------------------------------------------------------------------------
package rc5_pkg;

    localparam int W     = 16;
    localparam int C     = 8;
    localparam int MAX_T = 64;

    localparam logic [W-1:0] P16 = 16'hB7E1;
    localparam logic [W-1:0] Q16 = 16'h9E37;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // Rotate through a doubled word so that amt = 0 needs no special case.
    function automatic logic [W-1:0] rotl16(input logic [W-1:0] word,
                                            input logic [3:0]   amt);
        logic [2*W-1:0] dbl;
        dbl = {word, word} << amt;
        return dbl[2*W-1:W];
    endfunction

endpackage

// File: rtl/rc5_key_schedule.sv
// ---------------------------------------------------------------------------
// rc5_key_schedule
//   RC5-16 key expansion. Expands a 128-bit user key into the round-key
//   table S[0..t-1], t = 2*(r+1), performing one mixing iteration per clock.
//   Ports:
//     clk        : system clock
//     rst        : synchronous reset, active low
//     start      : one-cycle request, honoured only in IDLE
//     num_rounds : r (0..31), captured on start
//     key        : user key, captured on start; word i = key[16i+15:16i]
//     busy       : expansion in progress (INIT and MIX)
//     done       : one-cycle pulse when the table is complete
//     ready      : table valid until the next accepted start or reset
//     s_addr     : table read index
//     s_data     : S[s_addr] when ready and s_addr < t, else zero
//                  (combinational read)
// ---------------------------------------------------------------------------
module rc5_key_schedule
    import rc5_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [4:0]     num_rounds,
    input  logic [127:0]   key,
    output logic           busy,
    output logic           done,
    output logic           ready,
    input  logic [5:0]     s_addr,
    output logic [W-1:0]   s_data
);

    // Control state
    state_e         state_q, state_d;
    logic [6:0]     t_q,     t_d;       // table length, up to 64
    logic [7:0]     m_q,     m_d;       // mixing iterations, up to 192
    logic [5:0]     i_q,     i_d;
    logic [2:0]     j_q,     j_d;
    logic [7:0]     k_q,     k_d;
    logic [W-1:0]   a_q,     a_d;
    logic [W-1:0]   b_q,     b_d;
    logic [W-1:0]   acc_q,   acc_d;     // running P16 + i*Q16
    logic           busy_q,  busy_d;
    logic           done_q,  done_d;
    logic           ready_q, ready_d;

    // Table storage (never reset; contents only meaningful while ready)
    logic [W-1:0]   s_mem [MAX_T];
    logic [W-1:0]   l_mem [C];

    logic           s_we;
    logic [W-1:0]   s_wdata;
    logic           l_load;
    logic           l_we;

    // Start-time derived values
    logic [6:0]     t_start;
    logic [7:0]     m_start;

    // Mixing datapath
    logic [W-1:0]   sum_a, a_new, ab_sum, sum_b, b_new;
    logic [6:0]     i_inc;

    assign t_start = 7'({num_rounds, 1'b0}) + 7'd2;
    // max(t, C) only differs from t for r < 3
    assign m_start = (t_start > 7'(C)) ? 8'(t_start) * 8'd3 : 8'(3 * C);

    // A' is forwarded straight into the B' computation within the cycle.
    assign sum_a  = s_mem[i_q] + a_q + b_q;
    assign a_new  = rotl16(sum_a, 4'd3);
    assign ab_sum = a_new + b_q;
    assign sum_b  = l_mem[j_q] + ab_sum;
    assign b_new  = rotl16(sum_b, ab_sum[3:0]);

    assign i_inc  = {1'b0, i_q} + 7'd1;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        m_d     = m_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ready_d = ready_q;
        s_we    = 1'b0;
        s_wdata = acc_q;
        l_load  = 1'b0;
        l_we    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INIT;
                    t_d     = t_start;
                    m_d     = m_start;
                    i_d     = '0;
                    acc_d   = P16;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    l_load  = 1'b1;
                end
            end
            INIT: begin
                s_we    = 1'b1;
                s_wdata = acc_q;
                acc_d   = acc_q + Q16;
                if (i_inc == t_q) begin
                    state_d = MIX;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    a_d     = '0;
                    b_d     = '0;
                end else begin
                    i_d = i_inc[5:0];
                end
            end
            MIX: begin
                s_we    = 1'b1;
                s_wdata = a_new;
                l_we    = 1'b1;
                a_d     = a_new;
                b_d     = b_new;
                i_d     = (i_inc == t_q) ? 6'd0 : i_inc[5:0];
                j_d     = j_q + 3'd1;
                k_d     = k_q + 8'd1;
                if (k_d == m_q) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            t_q     <= 7'd2;
            m_q     <= 8'd24;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            m_q     <= m_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    // Storage writes are gated by the FSM, which is itself held in IDLE
    // during reset, so the arrays need no reset of their own.
    always_ff @(posedge clk) begin
        if (rst && s_we)
            s_mem[i_q] <= s_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (l_load) begin
                for (int n = 0; n < C; n++)
                    l_mem[n] <= key[16*n +: 16];
            end else if (l_we) begin
                l_mem[j_q] <= b_new;
            end
        end
    end

    always_comb begin
        s_data = '0;
        if (ready_q && ({1'b0, s_addr} < t_q))
            s_data = s_mem[s_addr];
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign ready = ready_q;

endmodule
